// File: rtl/fetch_queue.sv
// fetch_queue: decoupling queue between instruction fetch and decode.
// Fetch pushes up to two instructions per cycle; decode is shown the two
// oldest entries and pops everything it was shown unless it stalls.
// Optional build macro: FETCH_QUEUE_BYPASS_EN (an empty queue forwards the
// incoming instructions to decode in the same cycle).
//
// Handshakes: a push happens on a clk edge where in_valid && in_ready; in_ready
// depends only on registered occupancy, so fetch may raise in_valid without
// waiting for it. A pop happens on an edge where valid && !next_stalled and
// removes exactly out_count entries. clear and reset drop both that cycle.

package fetch_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetched_instruction;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [1:0]               in_count,
  input  fetched_instruction       instr_in_1,
  input  fetched_instruction       instr_in_2,
  output logic                     in_ready,
  input  logic                     next_stalled,
  output logic                     valid,
  output fetched_instruction       instruction_1,
  output fetched_instruction       instruction_2,
  output logic [1:0]               out_count,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  fetched_instruction mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [OW-1:0] occ;
  logic [1:0]    in_eff;
  logic [1:0]    q_cnt;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic          push_ok;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign head_p1   = head + AW'(1);
  assign tail_p1   = tail + AW'(1);
  assign in_eff    = (in_count == 2'd3) ? 2'd2 : in_count;
  // Conservative: room for a full 2-wide push regardless of this cycle's pop.
  assign in_ready  = (occ <= OW'(DEPTH - 2));
  assign push_ok   = in_valid && in_ready;
  assign q_cnt     = (occ >= OW'(2)) ? 2'd2 : occ[1:0];
  assign occupancy = occ;

  // Output selection and push/pop amounts for this cycle.
  always_comb begin
    out_count     = q_cnt;
    instruction_1 = (occ != '0)     ? mem[head]    : '0;
    instruction_2 = (occ >= OW'(2)) ? mem[head_p1] : '0;
    push_n        = push_ok ? in_eff : 2'd0;
    pop_n         = (q_cnt != 2'd0 && !next_stalled) ? q_cnt : 2'd0;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: show the inputs directly; store them only if decode stalls.
    if (occ == '0 && push_ok) begin
      out_count     = in_eff;
      instruction_1 = (in_eff != 2'd0) ? instr_in_1 : '0;
      instruction_2 = (in_eff == 2'd2) ? instr_in_2 : '0;
      pop_n         = 2'd0;
      push_n        = next_stalled ? in_eff : 2'd0;
    end
`endif
    valid = (out_count != 2'd0);
  end

  // Pointer and occupancy update; reset beats clear, clear beats push/pop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + AW'(pop_n);
      tail <= tail + AW'(push_n);
      occ  <= occ + OW'(push_n) - OW'(pop_n);
    end
  end

  // Storage writes in program order; contents need no reset.
  always_ff @(posedge clk) begin
    if (!reset && !clear) begin
      if (push_n != 2'd0) mem[tail]    <= instr_in_1;
      if (push_n == 2'd2) mem[tail_p1] <= instr_in_2;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: drives fetch_queue with directed and random traffic and
// compares every cycle against a queue-based model of the intended behaviour.
// Build with FETCH_QUEUE_BYPASS_EN defined to check the bypass variant.

module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic [1:0]         in_count = 2'd0;
  fetched_instruction instr_in_1 = '0;
  fetched_instruction instr_in_2 = '0;
  logic               in_ready;
  logic               next_stalled = 1'b1;
  logic               valid;
  fetched_instruction instruction_1;
  fetched_instruction instruction_2;
  logic [1:0]         out_count;
  logic [OW-1:0]      occupancy;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_count(in_count),
    .instr_in_1(instr_in_1), .instr_in_2(instr_in_2),
    .in_ready(in_ready), .next_stalled(next_stalled),
    .valid(valid), .instruction_1(instruction_1), .instruction_2(instruction_2),
    .out_count(out_count), .occupancy(occupancy)
  );

  // clock
  always #5 clk = ~clk;

  // model state
  fetched_instruction exp_q[$];
  int checks = 0;
  int errors = 0;

  // expectations for the current cycle, filled by model_check
  logic               e_ready, e_valid, e_byp;
  logic [1:0]         e_cnt;
  fetched_instruction e_i1, e_i2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] eff_count(input logic [1:0] c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction

  // Compute what decode must see right now, then compare.
  task automatic model_check();
    int n;
    n       = exp_q.size();
    e_ready = (DEPTH - n) >= 2;
    e_byp   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    e_byp   = (n == 0) && in_valid && e_ready;
`endif
    if (e_byp) begin
      e_cnt = eff_count(in_count);
      e_i1  = (e_cnt >= 2'd1) ? instr_in_1 : '0;
      e_i2  = (e_cnt == 2'd2) ? instr_in_2 : '0;
    end else begin
      e_cnt = (n >= 2) ? 2'd2 : 2'(n);
      e_i1  = (n >= 1) ? exp_q[0] : '0;
      e_i2  = (n >= 2) ? exp_q[1] : '0;
    end
    e_valid = (e_cnt != 2'd0);
    chk("in_ready", 64'(in_ready), 64'(e_ready));
    chk("valid", 64'(valid), 64'(e_valid));
    chk("out_count", 64'(out_count), 64'(e_cnt));
    chk("instruction_1", instruction_1, e_i1);
    chk("instruction_2", instruction_2, e_i2);
    chk("occupancy", 64'(occupancy), 64'(n));
  endtask

  // Apply the clock edge to the model using the inputs held across it.
  task automatic model_update();
    int popped;
    int pushed;
    if (reset || clear) begin
      exp_q.delete();
    end else begin
      popped = (e_valid && !next_stalled) ? int'(e_cnt) : 0;
      pushed = (in_valid && e_ready) ? int'(eff_count(in_count)) : 0;
      if (e_byp) begin
        popped = 0;
        if (!next_stalled) pushed = 0;
      end
      for (int i = 0; i < popped; i++) void'(exp_q.pop_front());
      if (pushed >= 1) exp_q.push_back(instr_in_1);
      if (pushed == 2) exp_q.push_back(instr_in_2);
    end
  endtask

  // Driver: one clock cycle with the given inputs; returns at posedge+1
  // with fetch idle and clear/reset released.
  task automatic cycle(input logic v, input logic [1:0] cnt,
                       input fetched_instruction a, input fetched_instruction b,
                       input logic stall, input logic clr, input logic rst);
    in_valid     = v;
    in_count     = cnt;
    instr_in_1   = a;
    instr_in_2   = b;
    next_stalled = stall;
    clear        = clr;
    reset        = rst;
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
    in_valid = 1'b0;
    in_count = 2'd0;
    clear    = 1'b0;
    reset    = 1'b0;
  endtask

  function automatic fetched_instruction mk(input int tag);
    fetched_instruction f;
    f.pc    = 32'h1000 + 32'(tag) * 4;
    f.instr = 32'hC0DE_0000 + 32'(tag);
    return f;
  endfunction

  function automatic fetched_instruction rnd();
    fetched_instruction f;
    f.pc    = $urandom;
    f.instr = $urandom;
    return f;
  endfunction

  fetched_instruction z = '0;

  initial begin
    // reset state (DUT is unknown before the first reset edge)
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_out_count", 64'(out_count), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_instruction_1", instruction_1, 64'd0);
    chk("reset_instruction_2", instruction_2, 64'd0);

    // push A,B -> visible next cycle
    cycle(1, 2, mk(1), mk(2), 1, 0, 0);
    chk("ab_valid", 64'(valid), 64'd1);
    chk("ab_out_count", 64'(out_count), 64'd2);
    chk("ab_instruction_1", instruction_1, mk(1));
    chk("ab_instruction_2", instruction_2, mk(2));
    chk("ab_occupancy", 64'(occupancy), 64'd2);

    // fill to DEPTH, then an extra push is refused
    cycle(0, 0, z, z, 1, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 2, mk(10 + 2*i), mk(11 + 2*i), 1, 0, 0);
    chk("full_occupancy", 64'(occupancy), 64'd8);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    cycle(1, 2, mk(90), mk(91), 1, 0, 0);
    chk("full_ignored_occupancy", 64'(occupancy), 64'd8);
    chk("full_head", instruction_1, mk(10));

    // simultaneous pop of 2 and push of 2
    cycle(0, 0, z, z, 1, 0, 1);
    cycle(1, 2, mk(21), mk(22), 1, 0, 0);
    cycle(1, 1, mk(23), z, 1, 0, 0);
    cycle(1, 2, mk(24), mk(25), 0, 0, 0);
    chk("pushpop_occupancy", 64'(occupancy), 64'd3);
    chk("pushpop_instruction_1", instruction_1, mk(23));
    chk("pushpop_instruction_2", instruction_2, mk(24));

    // wrap: bring head to 7 with one entry X, then push Y,Z while popping X
    cycle(0, 0, z, z, 1, 0, 1);
    cycle(1, 1, mk(30), z, 1, 0, 0);
    cycle(0, 0, z, z, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 2, mk(31 + 2*i), mk(32 + 2*i), 1, 0, 0);
    cycle(1, 1, mk(40), z, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, z, z, 0, 0, 0);
    chk("wrap_pre_occupancy", 64'(occupancy), 64'd1);
    chk("wrap_pre_instruction_1", instruction_1, mk(40));
    cycle(1, 2, mk(41), mk(42), 0, 0, 0);
    chk("wrap_instruction_1", instruction_1, mk(41));
    chk("wrap_instruction_2", instruction_2, mk(42));
    chk("wrap_occupancy", 64'(occupancy), 64'd2);

    // clear while pushing and popping
    cycle(0, 0, z, z, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 2, mk(50 + 2*i), mk(51 + 2*i), 1, 0, 0);
    chk("clear_pre_occupancy", 64'(occupancy), 64'd6);
    cycle(1, 2, mk(60), mk(61), 0, 1, 0);
    chk("clear_occupancy", 64'(occupancy), 64'd0);
    chk("clear_valid", 64'(valid), 64'd0);
    chk("clear_in_ready", 64'(in_ready), 64'd1);

`ifdef FETCH_QUEUE_BYPASS_EN
    // bypass: empty queue, decode ready, A appears in the same cycle
    in_valid = 1'b1; in_count = 2'd1; instr_in_1 = mk(70); instr_in_2 = z;
    next_stalled = 1'b0;
    #1;
    chk("byp_valid", 64'(valid), 64'd1);
    chk("byp_out_count", 64'(out_count), 64'd1);
    chk("byp_instruction_1", instruction_1, mk(70));
    cycle(1, 1, mk(70), z, 0, 0, 0);
    chk("byp_occupancy", 64'(occupancy), 64'd0);
`endif

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd(), rnd(),
            $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
